decode_stage: RTL and testbench

//  ID stage of the five-stage pipeline. Sits between the fetch stage's IF/ID outputs and the EX stage.
//  - Decodes each 16-bit instruction word.
//  - Owns the 8-entry register file, written from write-back.
//  - Joins two-word immediate instructions: the instruction word plus the following immediate word.
//  - Drives the registered ID/EX buffer, with stall and flush control.

---
 rtl/decode_stage.sv | 155 +++++++++++++++
 tb/tb_decode_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ID stage: decodes 16-bit words, joins two-word immediates, owns the 8-entry register file and the ID/EX buffer.
// Optional: define DECODE_REG_BYPASS_EN for a write-first register file (write-back data forwarded to same-cycle reads).
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       instr,
  input  logic [PC_W-1:0]   if_next_pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              fetch_hold,
  output logic              id_valid,
  output logic [4:0]        id_opcode,
  output logic [2:0]        id_rd_addr,
  output logic [2:0]        id_rs_addr,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [3:0]        id_shamt,
  output logic              id_has_imm,
  output logic [DATA_W-1:0] id_imm,
  output logic [PC_W-1:0]   id_pc
);

  localparam int NUM_REGS = 8;

  typedef enum logic {S_INSTR, S_IMM} state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  // Fields of the first word of a two-word instruction, held until its immediate arrives.
  logic [4:0]        hold_opcode_reg;
  logic [2:0]        hold_rd_reg;
  logic [2:0]        hold_rs_reg;
  logic [3:0]        hold_shamt_reg;
  logic [PC_W-1:0]   hold_pc_reg;

  logic [4:0]        src_opcode;
  logic [2:0]        src_rd;
  logic [2:0]        src_rs;
  logic [3:0]        src_shamt;
  logic [PC_W-1:0]   src_pc;
  logic [DATA_W-1:0] src_imm;
  logic              src_has_imm;
  logic [DATA_W-1:0] rd_data_next;
  logic [DATA_W-1:0] rs_data_next;
  logic              in_imm;

  assign fetch_hold = stall;
  assign in_imm     = (state_reg == S_IMM);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (wb_en && (wb_addr == 3'(gi))) begin
          regs_reg[gi] <= wb_data;
        end
      end
    end
  endgenerate

  // Issue source: held fields when completing a two-word instruction, else the live word.
  always_comb begin
    src_opcode  = instr[15:11];
    src_rs      = instr[10:8];
    src_rd      = instr[7:5];
    src_shamt   = instr[4:1];
    src_pc      = if_next_pc;
    src_imm     = '0;
    src_has_imm = 1'b0;
    if (in_imm) begin
      src_opcode  = hold_opcode_reg;
      src_rs      = hold_rs_reg;
      src_rd      = hold_rd_reg;
      src_shamt   = hold_shamt_reg;
      src_pc      = hold_pc_reg;
      src_imm     = DATA_W'(instr);
      src_has_imm = 1'b1;
    end
  end

  always_comb begin
    rd_data_next = regs_reg[src_rd];
    rs_data_next = regs_reg[src_rs];
`ifdef DECODE_REG_BYPASS_EN
    if (wb_en && (wb_addr == src_rd)) rd_data_next = wb_data;
    if (wb_en && (wb_addr == src_rs)) rs_data_next = wb_data;
`else
    // Read-first: a same-cycle write is not visible; the hazard unit covers it with a stall.
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_INSTR;
      hold_opcode_reg <= '0;
      hold_rd_reg     <= '0;
      hold_rs_reg     <= '0;
      hold_shamt_reg  <= '0;
      hold_pc_reg     <= '0;
      id_valid        <= 1'b0;
      id_opcode       <= '0;
      id_rd_addr      <= '0;
      id_rs_addr      <= '0;
      id_rd_data      <= '0;
      id_rs_data      <= '0;
      id_shamt        <= '0;
      id_has_imm      <= 1'b0;
      id_imm          <= '0;
      id_pc           <= '0;
    end else if (flush) begin
      id_valid        <= 1'b0;
      state_reg       <= S_INSTR;
      hold_opcode_reg <= '0;
      hold_rd_reg     <= '0;
      hold_rs_reg     <= '0;
      hold_shamt_reg  <= '0;
      hold_pc_reg     <= '0;
    end else if (!stall) begin
      if (!if_valid) begin
        id_valid <= 1'b0;
      end else if (!in_imm && instr[0]) begin
        hold_opcode_reg <= instr[15:11];
        hold_rs_reg     <= instr[10:8];
        hold_rd_reg     <= instr[7:5];
        hold_shamt_reg  <= instr[4:1];
        hold_pc_reg     <= if_next_pc;
        id_valid        <= 1'b0;
        state_reg       <= S_IMM;
      end else begin
        id_valid   <= 1'b1;
        id_opcode  <= src_opcode;
        id_rd_addr <= src_rd;
        id_rs_addr <= src_rs;
        id_rd_data <= rd_data_next;
        id_rs_data <= rs_data_next;
        id_shamt   <= src_shamt;
        id_has_imm <= src_has_imm;
        id_imm     <= src_imm;
        id_pc      <= src_pc;
        state_reg  <= S_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX entries are queued when words are driven and popped on id_valid.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, stall, flush, wb_en;
  logic [15:0] instr;
  logic [31:0] if_next_pc;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        fetch_hold, id_valid, id_has_imm;
  logic [4:0]  id_opcode;
  logic [2:0]  id_rd_addr, id_rs_addr;
  logic [15:0] id_rd_data, id_rs_data, id_imm;
  logic [3:0]  id_shamt;
  logic [31:0] id_pc;

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] rdd;
    logic [15:0] rsd;
    logic [3:0]  sh;
    logic        hi;
    logic [15:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  logic [15:0] shadow [8];
  int          checks = 0;
  int          errors = 0;

  decode_stage #(.DATA_W(16), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .if_next_pc(if_next_pc),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fetch_hold(fetch_hold), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd_addr(id_rd_addr), .id_rs_addr(id_rs_addr), .id_rd_data(id_rd_data),
    .id_rs_data(id_rs_data), .id_shamt(id_shamt), .id_has_imm(id_has_imm),
    .id_imm(id_imm), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] w, input logic [15:0] imm, input logic hi,
                              input logic [31:0] pc, input logic [15:0] rdd, input logic [15:0] rsd);
    exp_t e;
    e.op = w[15:11]; e.rs = w[10:8]; e.rd = w[7:5]; e.sh = w[4:1];
    e.rdd = rdd; e.rsd = rsd; e.hi = hi; e.imm = imm; e.pc = pc;
    return e;
  endfunction

  task automatic idle_inputs();
    if_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_en = 1'b0; rst = 1'b0;
  endtask

  // One clock; checks the valid flag and, on an issue, the oldest scoreboard entry.
  task automatic tick(input logic exp_issue);
    exp_t e;
    @(posedge clk); #1;
    check_eq("id_valid", id_valid, exp_issue);
    if (id_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        last_exp = e;
        check_eq("opcode", id_opcode, e.op);
        check_eq("rd_addr", id_rd_addr, e.rd);
        check_eq("rs_addr", id_rs_addr, e.rs);
        check_eq("rd_data", id_rd_data, e.rdd);
        check_eq("rs_data", id_rs_data, e.rsd);
        check_eq("shamt", id_shamt, e.sh);
        check_eq("has_imm", id_has_imm, e.hi);
        check_eq("imm", id_imm, e.imm);
        check_eq("pc", id_pc, e.pc);
        $display("issue op=%0d rd=%0d rs=%0d rdd=%h rsd=%h imm=%h pc=%h",
                 id_opcode, id_rd_addr, id_rs_addr, id_rd_data, id_rs_data, id_imm, id_pc);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, id_valid, 0);
    check_eq({tag, "_op"}, id_opcode, 0);
    check_eq({tag, "_rd"}, id_rd_addr, 0);
    check_eq({tag, "_rs"}, id_rs_addr, 0);
    check_eq({tag, "_rdd"}, id_rd_data, 0);
    check_eq({tag, "_rsd"}, id_rs_data, 0);
    check_eq({tag, "_sh"}, id_shamt, 0);
    check_eq({tag, "_hi"}, id_has_imm, 0);
    check_eq({tag, "_imm"}, id_imm, 0);
    check_eq({tag, "_pc"}, id_pc, 0);
    $display("reset check %s", tag);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick(1'b0);
    wb_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic issue1(input logic [15:0] w, input logic [31:0] pc);
    sb.push_back(mk(w, 16'h0, 1'b0, pc, shadow[w[7:5]], shadow[w[10:8]]));
    if_valid = 1'b1; instr = w; if_next_pc = pc;
    tick(1'b1);
    if_valid = 1'b0;
  endtask

  task automatic first_word(input logic [15:0] w, input logic [31:0] pc);
    if_valid = 1'b1; instr = w; if_next_pc = pc;
    tick(1'b0);
    if_valid = 1'b0;
  endtask

  task automatic second_word(input logic [15:0] w, input logic [15:0] imm, input logic [31:0] pc);
    sb.push_back(mk(w, imm, 1'b1, pc, shadow[w[7:5]], shadow[w[10:8]]));
    if_valid = 1'b1; instr = imm; if_next_pc = pc + 32'd2;
    tick(1'b1);
    if_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  ri;
    logic [15:0] w;
    idle_inputs();
    instr = 16'h8360; if_next_pc = 32'h10; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 8; i++) shadow[i] = 16'h0;

    // Reset with a valid word present and a pending write.
    rst = 1'b1; if_valid = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hFFFF;
    @(posedge clk); #1; check_reset_outputs("rst1");
    @(posedge clk); #1; check_reset_outputs("rst2");
    idle_inputs();

    for (int i = 0; i < 8; i++) begin
      ri = 3'(i);
      w = {5'd2, ri, 3'(7 - i), 4'd5, 1'b0};
      issue1(w, 32'h100 + 32'(i));
    end

    wb_write(3'd3, 16'hA5A5);
    wb_write(3'd0, 16'h1357);
    wb_write(3'd1, 16'h2468);
    wb_write(3'd2, 16'h1111);
    wb_write(3'd4, 16'h4444);
    issue1(16'h8360, 32'h10);

    // Two-word instruction; fields hold through an idle cycle.
    first_word(16'h0821, 32'h20);
    second_word(16'h0821, 16'h1234, 32'h20);
    tick(1'b0);
    check_eq("idle_hold_imm", id_imm, last_exp.imm);
    check_eq("idle_hold_pc", id_pc, last_exp.pc);

    // Stall on a valid entry keeps it valid.
    issue1(16'h0A80, 32'h30);
    stall = 1'b1; if_valid = 1'b1; instr = 16'h8360; if_next_pc = 32'h34;
    @(posedge clk); #1;
    check_eq("stall_valid_hold", id_valid, 1);
    check_eq("stall_rsd_hold", id_rs_data, last_exp.rsd);
    check_eq("fetch_hold", fetch_hold, 1);
    stall = 1'b0; if_valid = 1'b0;
    tick(1'b0);

    // Stall in S_IMM; register writes continue meanwhile.
    first_word(16'h0821, 32'h50);
    stall = 1'b1; if_valid = 1'b1; instr = 16'hFFFF; if_next_pc = 32'h99;
    for (int i = 0; i < 3; i++) begin
      wb_en = (i == 1); wb_addr = 3'd1; wb_data = 16'hD00D;
      tick(1'b0);
      check_eq("stall_op_hold", id_opcode, last_exp.op);
      check_eq("stall_pc_hold", id_pc, last_exp.pc);
    end
    shadow[1] = 16'hD00D;
    stall = 1'b0; wb_en = 1'b0;
    check_eq("fetch_release", fetch_hold, 0);
    second_word(16'h0821, 16'hBEEF, 32'h50);

    // Flush in S_IMM: next word is a fresh instruction.
    first_word(16'h0821, 32'h60);
    flush = 1'b1; if_valid = 1'b1; instr = 16'h1234;
    tick(1'b0);
    flush = 1'b0;
    issue1(16'h8360, 32'h64);

    // Flush wins over stall.
    first_word(16'h0821, 32'h70);
    flush = 1'b1; stall = 1'b1; if_valid = 1'b1; instr = 16'h1234;
    tick(1'b0);
    flush = 1'b0; stall = 1'b0;
    issue1(16'h8360, 32'h74);

    // Same-cycle write-back to an operand being read.
    w = 16'h0A80;
`ifdef DECODE_REG_BYPASS_EN
    sb.push_back(mk(w, 16'h0, 1'b0, 32'h90, shadow[4], 16'h00FF));
`else
    sb.push_back(mk(w, 16'h0, 1'b0, 32'h90, shadow[4], shadow[2]));
`endif
    if_valid = 1'b1; instr = w; if_next_pc = 32'h90;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00FF;
    tick(1'b1);
    wb_en = 1'b0; if_valid = 1'b0;
    shadow[2] = 16'h00FF;
    issue1(16'h0A80, 32'h94);

    // Reset in S_IMM with stall and flush both high.
    first_word(16'h0821, 32'hA0);
    rst = 1'b1; stall = 1'b1; flush = 1'b1; if_valid = 1'b1; instr = 16'hFFFF;
    @(posedge clk); #1;
    check_reset_outputs("rst_imm");
    idle_inputs();
    for (int i = 0; i < 8; i++) shadow[i] = 16'h0;
    issue1(16'h8360, 32'hB0);
    issue1(16'h0A80, 32'hB4);

    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
